// File: rtl/imm_ext_pkg.sv
// Shared types for the pipelined immediate-extension stage.
package imm_ext_pkg;

  // Extension mode carried alongside each immediate.
  typedef enum logic [1:0] {
    SIGN    = 2'b00,
    ZERO    = 2'b01,
    UPPER   = 2'b10,
    ILLEGAL = 2'b11
  } ext_mode_t;

  // Occupancy of the two-entry output/skid buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    HALF  = 2'b01,
    FULL  = 2'b10
  } skid_state_t;

  // Default widths for the MIPS datapath instance.
  localparam int DEF_IN_W  = 16;
  localparam int DEF_OUT_W = 32;
  localparam int DEF_CNT_W = 16;

endpackage : imm_ext_pkg

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: (data, mode) -> (extended data, err).
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic [IN_W-1:0]  i_data,
  input  ext_mode_t        i_mode,
  output logic [OUT_W-1:0] o_data,
  output logic             o_err
);

  localparam int PAD = OUT_W - IN_W;

  logic [OUT_W-1:0] w_zext;
  logic [OUT_W-1:0] w_sext;
  logic [OUT_W-1:0] w_upper;

  // Size casts handle IN_W == OUT_W without a zero-width replication.
  assign w_zext  = OUT_W'(i_data);
  assign w_sext  = OUT_W'($signed(i_data));
  assign w_upper = w_zext << PAD;

  // Select the extension; any unknown encoding is reported as an error beat.
  always_comb begin
    o_data = '0;
    o_err  = 1'b0;
    case (i_mode)
      SIGN:    o_data = w_sext;
      ZERO:    o_data = w_zext;
      UPPER:   o_data = w_upper;
      ILLEGAL: begin
        o_data = '0;
        o_err  = 1'b1;
      end
      default: begin
        o_data = '0;
        o_err  = 1'b1;
      end
    endcase
  end

endmodule : imm_ext_core

// File: rtl/imm_ext_pipe.sv
// Pipelined immediate-extension stage with a two-entry skid buffer and
// an output-transfer counter. in_ready depends only on registered state.
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  ext_mode_t        in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_err,
  output logic [CNT_W-1:0] xfer_count
);

  // One stored beat: extended data plus its error flag.
  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic             err;
  } entry_t;

  skid_state_t      r_state;
  entry_t           r_out;
  entry_t           r_skid;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_count;

  logic [OUT_W-1:0] w_ext_data;
  logic             w_ext_err;
  entry_t           w_new;
  logic             w_in_fire;
  logic             w_out_fire;

  imm_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .i_data (in_data),
    .i_mode (in_mode),
    .o_data (w_ext_data),
    .o_err  (w_ext_err)
  );

  assign w_new      = '{data: w_ext_data, err: w_ext_err};
  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & out_ready;

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out.data;
  assign out_err    = r_out.err;
  assign xfer_count = r_count;

  // Skid FSM, entry registers, registered handshake flags and transfer counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= EMPTY;
      r_out       <= '0;
      r_skid      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_count     <= '0;
    end else begin
      if (w_out_fire) begin
        r_count <= r_count + CNT_W'(1);
      end
      case (r_state)
        EMPTY: begin
          if (w_in_fire) begin
            r_out       <= w_new;
            r_state     <= HALF;
            r_out_valid <= 1'b1;
          end
        end
        HALF: begin
          if (w_in_fire && w_out_fire) begin
            // Pass-through: the new beat replaces the departing one directly.
            r_out <= w_new;
          end else if (w_in_fire) begin
            r_skid     <= w_new;
            r_state    <= FULL;
            r_in_ready <= 1'b0;
          end else if (w_out_fire) begin
            r_state     <= EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        FULL: begin
          if (w_out_fire) begin
            r_out      <= r_skid;
            r_state    <= HALF;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule : imm_ext_pipe
